// File: rtl/hpdcache_dir_sched_pkg.sv
// Shared types for the directory bank scheduler: request struct and response source tag.
package hpdcache_dir_sched_pkg;

    localparam int unsigned DIR_NUM_WAYS = 4;
    localparam int unsigned DIR_SETS_W   = 6;
    localparam int unsigned DIR_ENTRY_W  = 8;

    typedef logic [DIR_SETS_W-1:0]   hpdcache_dir_addr_t;
    typedef logic [DIR_NUM_WAYS-1:0] hpdcache_way_vector_t;
    typedef logic [DIR_ENTRY_W-1:0]  hpdcache_dir_entry_t;

    typedef enum logic [1:0] {
        DIR_SRC_NONE,
        DIR_SRC_CORE,
        DIR_SRC_COH
    } dir_sched_src_e;

    typedef struct packed {
        hpdcache_dir_addr_t                        addr;
        hpdcache_way_vector_t                      cs;
        hpdcache_way_vector_t                      we;
        hpdcache_dir_entry_t [DIR_NUM_WAYS-1:0]    wentry;
    } dir_sched_req_t;

    // Only pure reads produce a tagged response.
    function automatic logic is_read(dir_sched_req_t r);
        return (|r.cs) && !(|r.we);
    endfunction

endpackage

// File: rtl/hpdcache_dir_sched_buf.sv
// In-order core request buffer (shift FIFO, no fall-through); exposes every entry
// so the scheduler can check coherence requests against buffered writes.
module hpdcache_dir_sched_buf
    import hpdcache_dir_sched_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  logic                                pop,
    input  dir_sched_req_t                      wdata,
    output dir_sched_req_t                      head,
    output logic                                full,
    output logic                                empty,
    output logic                 [Depth-1:0]    valid,
    output hpdcache_dir_addr_t   [Depth-1:0]    addr,
    output hpdcache_way_vector_t [Depth-1:0]    we
);

    localparam int unsigned CntW = $clog2(Depth + 1);

    dir_sched_req_t [Depth-1:0] mem_q, mem_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [CntW-1:0]            wr_idx;
    logic                       push_ok;

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !full;
    assign head    = mem_q[0];
    assign wr_idx  = cnt_q - CntW'(pop);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop);
        // Entry 0 is always the head; a pop shifts everything down by one slot.
        if (pop) begin
            mem_d = mem_q >> $bits(dir_sched_req_t);
        end
        if (push_ok) begin
            mem_d[wr_idx] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        valid = '0;
        addr  = '0;
        we    = '0;
        for (int i = 0; i < Depth; i++) begin
            valid[i] = (CntW'(i) < cnt_q);
            addr[i]  = mem_q[i].addr;
            we[i]    = mem_q[i].we;
        end
    end

endmodule

// File: rtl/hpdcache_dir_sched.sv
// Directory SRAM bank scheduler: buffered core requests vs. unbuffered coherence requests.
// Optional anti-starvation burst limit enabled by HPDCACHE_DIR_SCHED_FAIRNESS_EN.
module hpdcache_dir_sched
    import hpdcache_dir_sched_pkg::*;
#(
    parameter int unsigned NumWays      = DIR_NUM_WAYS,
    parameter int unsigned CoreBufDepth = 2,
    parameter int unsigned MaxCohBurst  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic                             core_valid_i,
    output logic                             core_ready_o,
    input  logic [DIR_SETS_W-1:0]            core_addr_i,
    input  logic [NumWays-1:0]               core_cs_i,
    input  logic [NumWays-1:0]               core_we_i,
    input  logic [NumWays*DIR_ENTRY_W-1:0]   core_wentry_i,

    input  logic                             coh_valid_i,
    output logic                             coh_ready_o,
    input  logic [DIR_SETS_W-1:0]            coh_addr_i,
    input  logic [NumWays-1:0]               coh_cs_i,
    input  logic [NumWays-1:0]               coh_we_i,
    input  logic [NumWays*DIR_ENTRY_W-1:0]   coh_wentry_i,

    output logic [DIR_SETS_W-1:0]            dir_addr_o,
    output logic [NumWays-1:0]               dir_cs_o,
    output logic [NumWays-1:0]               dir_we_o,
    output logic [NumWays*DIR_ENTRY_W-1:0]   dir_wentry_o,

    output logic                             rsp_core_o,
    output logic                             rsp_coh_o
);

    dir_sched_req_t                           core_req, coh_req, buf_head, sel_req;
    dir_sched_src_e                           sel_src, src_q;
    logic                                     buf_full, buf_empty;
    logic                 [CoreBufDepth-1:0]  buf_valid;
    hpdcache_dir_addr_t   [CoreBufDepth-1:0]  buf_addr;
    hpdcache_way_vector_t [CoreBufDepth-1:0]  buf_we;
    logic                                     hazard, starve;
    logic                                     grant_core, grant_coh;

    always_comb begin
        core_req        = '0;
        core_req.addr   = core_addr_i;
        core_req.cs     = core_cs_i;
        core_req.we     = core_we_i;
        core_req.wentry = core_wentry_i;
        coh_req         = '0;
        coh_req.addr    = coh_addr_i;
        coh_req.cs      = coh_cs_i;
        coh_req.we      = coh_we_i;
        coh_req.wentry  = coh_wentry_i;
    end

    hpdcache_dir_sched_buf #(
        .Depth (CoreBufDepth)
    ) i_buf (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (core_valid_i),
        .pop   (grant_core),
        .wdata (core_req),
        .head  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .valid (buf_valid),
        .addr  (buf_addr),
        .we    (buf_we)
    );

    assign core_ready_o = !buf_full;

    // A coherence access must not overtake a buffered core write to the same set.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < CoreBufDepth; i++) begin
            if (buf_valid[i] && (|buf_we[i]) && (buf_addr[i] == coh_addr_i)) begin
                hazard = 1'b1;
            end
        end
    end

`ifdef HPDCACHE_DIR_SCHED_FAIRNESS_EN
    localparam int unsigned BurstW = $clog2(MaxCohBurst + 1);

    logic [BurstW-1:0] burst_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            burst_q <= '0;
        end else if (grant_core || buf_empty) begin
            burst_q <= '0;
        end else if (grant_coh && (burst_q != BurstW'(MaxCohBurst))) begin
            burst_q <= burst_q + BurstW'(1);
        end
    end

    assign starve = (burst_q == BurstW'(MaxCohBurst));
`else
    logic unused_burst_cfg;
    assign unused_burst_cfg = ^MaxCohBurst;
    assign starve           = 1'b0;
`endif

    assign grant_coh   = coh_valid_i && !hazard && !(starve && !buf_empty);
    assign grant_core  = !buf_empty && !grant_coh;
    assign coh_ready_o = grant_coh;

    always_comb begin
        sel_req = coh_req;
        sel_src = DIR_SRC_NONE;
        if (grant_core) begin
            sel_req = buf_head;
        end
        if ((grant_core || grant_coh) && is_read(sel_req)) begin
            sel_src = grant_coh ? DIR_SRC_COH : DIR_SRC_CORE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_addr_o   <= '0;
            dir_cs_o     <= '0;
            dir_we_o     <= '0;
            dir_wentry_o <= '0;
            src_q        <= DIR_SRC_NONE;
            rsp_core_o   <= 1'b0;
            rsp_coh_o    <= 1'b0;
        end else begin
            if (grant_core || grant_coh) begin
                dir_addr_o   <= sel_req.addr;
                dir_cs_o     <= sel_req.cs;
                dir_we_o     <= sel_req.we;
                dir_wentry_o <= sel_req.wentry;
            end else begin
                // Idle: deselect the bank, keep address/data lines quiet.
                dir_cs_o <= '0;
                dir_we_o <= '0;
            end
            src_q      <= sel_src;
            rsp_core_o <= (src_q == DIR_SRC_CORE);
            rsp_coh_o  <= (src_q == DIR_SRC_COH);
        end
    end

endmodule

// File: doc/hpdcache_dir_sched.md
# hpdcache_dir_sched

Schedules accesses to one directory SRAM bank between the core request pipeline and the coherence (snoop) engine. Core requests are queued in a small in-order buffer. Coherence requests are unbuffered and have priority, subject to a same-set write hazard check and an optional anti-starvation burst limit. The issued access is registered onto the directory SRAM pins, and the read response is tagged back to its requester two cycles after grant.

## Interface
- NumWays, 4, directory ways per set
- CoreBufDepth, 2, core request buffer entries (≥1)
- MaxCohBurst, 4, consecutive coherence grants allowed while core is waiting (≥1)
- hpdcache_dir_addr_t, logic, directory set address type
- hpdcache_way_vector_t, logic, one-hot/multi-hot way select type
- hpdcache_dir_entry_t, logic, directory entry type
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- core_valid_i  in  1  core request valid
- core_ready_o  out  1  core request accepted when valid & ready
- core_addr_i / core_cs_i / core_we_i / core_wentry_i  in  addr_t / way_vector_t / way_vector_t / entry_t[NumWays]  core request fields
- coh_valid_i  in  1  coherence request valid
- coh_ready_o  out  1  coherence grant, same cycle
- coh_addr_i / coh_cs_i / coh_we_i / coh_wentry_i  in  as core  coherence request fields
- dir_addr_o / dir_cs_o / dir_we_o / dir_wentry_o  out  as core  registered SRAM access
- rsp_core_o  out  1  directory read data this cycle belongs to core
- rsp_coh_o  out  1  directory read data this cycle belongs to coherence

## Operation
- Core buffer: in-order FIFO, no fall-through. core_ready_o = !full. No push when full. Push and pop in the same cycle are allowed when not full.
- Candidates each cycle: core head (if buffer non-empty) and coherence input (if coh_valid_i).
- Hazard: coherence is blocked while any valid buffer entry has we != 0 and addr == coh_addr_i. Core head wins.
- Priority, highest first: hazard → core; starve flag set → core; coherence; core.
- At most one grant per cycle. coh_ready_o is the coherence grant. A core grant pops the head.
- Burst counter (width $clog2(MaxCohBurst+1)):
  - Increments on a coherence grant while the buffer is non-empty.
  - Clears on a core grant, or while the buffer is empty.
  - Saturates at MaxCohBurst.
  - starve = (count == MaxCohBurst).
- Idle cycle (no grant): dir_cs_o = 0 and dir_we_o = 0. Addr and wentry hold their previous values.
- Responses: rsp_core_o / rsp_coh_o pulse for granted accesses with cs != 0 and we == 0 (pure reads). They are one-hot and never both set.

## Timing
- Reset values: dir_addr_o, dir_cs_o, dir_we_o, dir_wentry_o = 0; rsp_core_o = rsp_coh_o = 0; buffer empty; counter 0; core_ready_o = 1.
- Coherence latency: grant in cycle N → dir_* valid in N+1 → rsp_coh_o in N+2.
- Core latency: accepted in N → earliest grant N+1 → dir_* in N+2 → rsp_core_o in N+3.
- Coherence requester must hold coh_* stable until coh_ready_o.
- Throughput: one SRAM access per cycle, back-to-back.
- Reset mid-operation: buffer, counter and response pipeline are cleared immediately (asynchronous). In-flight responses are dropped with no pulse.

## Configuration
- HPDCACHE_DIR_SCHED_FAIRNESS_EN defined: burst counter and starve rule are present as described.
- HPDCACHE_DIR_SCHED_FAIRNESS_EN undefined: no counter. Coherence always wins except on a hazard; MaxCohBurst is ignored.

## Structure
- Shared package hpdcache_dir_sched_pkg:
  - dir_sched_src_e {DIR_SRC_NONE, DIR_SRC_CORE, DIR_SRC_COH} for the response pipeline.
  - Packed request struct dir_sched_req_t parameterised by the directory types.
- Sub-module hpdcache_dir_sched_buf: FIFO that exposes all entry addresses, we fields and valid bits for the hazard compare.

## Test plan
- Core only, 3 back-to-back reads at addr 5, 6, 7:
  - dir_cs_o nonzero in cycles 2, 3, 4 with addr 5, 6, 7.
  - rsp_core_o high in cycles 3, 4, 5.
- Core and coherence valid in the same cycle, different sets, buffer holding 1 entry: coherence granted first (coh_ready_o = 1); core issued the next cycle.
- Hazard: buffer holds core write to addr 9; coh_valid_i with addr 9. Coherence stalls until the core write is granted, then is granted the cycle after.
- Fairness with MaxCohBurst = 4 and continuous coherence traffic to distinct sets plus one buffered core read:
  - Fairness enabled: 4 coherence grants, then the core grant.
  - Fairness disabled: core waits until coh_valid_i drops.
- Buffer full (CoreBufDepth = 2) under constant coherence traffic: core_ready_o = 0; it returns to 1 the cycle after a core grant.
- Reset asserted one cycle after a coherence read grant: no rsp_coh_o pulse, all dir_* = 0, core_ready_o = 1.
